// File: rtl/sram_port_arbiter_if.sv
// Requester, response and SRAM port A signals
// for the two-requester port arbiter.
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  rsp0_valid;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  rsp1_valid;

    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;

    logic                  sram_we;
    logic                  sram_enable;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_data_in;
    logic [DATA_WIDTH-1:0] sram_data_out;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid,
        output req1_ready, rsp1_valid,
        output rsp_rdata, init_done,
        output sram_we, sram_enable, sram_addr, sram_data_in,
        input  sram_data_out
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid,
        input  req1_ready, rsp1_valid,
        input  rsp_rdata, init_done,
        input  sram_we, sram_enable, sram_addr, sram_data_in,
        output sram_data_out
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for SRAM port A with a
// zero-fill sweep after every reset.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input logic clk,
    input logic rst,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  last_gnt;
    logic                  tag_valid;
    logic                  tag_id;
    logic                  run;
    logic                  gnt0;
    logic                  gnt1;

    // last_gnt=1 means req1 won last, so a tie goes to req0
    always_comb begin
        run  = (state == RUN) && !rst;
        gnt1 = run && bus.req1_valid &&
               (!bus.req0_valid || !last_gnt);
        gnt0 = run && bus.req0_valid && !gnt1;
    end

    always_comb begin
        bus.req0_ready   = 1'b0;
        bus.req1_ready   = 1'b0;
        bus.sram_we      = 1'b0;
        bus.sram_enable  = 1'b0;
        bus.sram_addr    = '0;
        bus.sram_data_in = '0;
        if (!rst && state == INIT) begin
            bus.sram_we   = 1'b1;
            bus.sram_addr = init_cnt;
        end else begin
            unique case (1'b1)
                gnt0: begin
                    bus.req0_ready   = 1'b1;
                    bus.sram_we      = bus.req0_we;
                    bus.sram_enable  = !bus.req0_we;
                    bus.sram_addr    = bus.req0_addr;
                    bus.sram_data_in = bus.req0_wdata;
                end
                gnt1: begin
                    bus.req1_ready   = 1'b1;
                    bus.sram_we      = bus.req1_we;
                    bus.sram_enable  = !bus.req1_we;
                    bus.sram_addr    = bus.req1_addr;
                    bus.sram_data_in = bus.req1_wdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp0_valid = !rst && tag_valid && !tag_id;
    assign bus.rsp1_valid = !rst && tag_valid && tag_id;
    assign bus.rsp_rdata  = bus.sram_data_out;
    assign bus.init_done  = !rst && (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            last_gnt  <= 1'b1;
            tag_valid <= 1'b0;
            tag_id    <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            unique case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1)
                        state <= RUN;
                end
                RUN: begin
                    if (gnt0 || gnt1)
                        last_gnt <= gnt1;
                    tag_valid <= (gnt0 && !bus.req0_we) ||
                                 (gnt1 && !bus.req1_we);
                    tag_id    <= gnt1;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter with a
// cycle-level memory and round-robin reference model.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    sram_port_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

    sram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] sram_mem [16];
    logic [15:0] sram_dout;
    assign bus.sram_data_out = sram_dout;

    initial begin
        for (int i = 0; i < 16; i++) sram_mem[i] = 16'hBAD0 + 16'(i);
        sram_dout = 16'h5555;
    end

    always @(posedge clk) begin
        if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_data_in;
        if (bus.sram_enable) sram_dout <= sram_mem[bus.sram_addr];
    end

    // reference model state
    logic [15:0] m_mem [16];
    int          m_cnt;
    int          m_last;
    bit          m_have;
    int          m_id;
    logic [15:0] m_data;

    bit          acc0, acc1;
    bit          o_rsp0, o_rsp1, o_init;
    logic [3:0]  o_addr;
    logic [15:0] o_rdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input bit v, input bit we,
                           input int a, input logic [15:0] d);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_we = we;
            bus.req0_addr = 4'(a); bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we;
            bus.req1_addr = 4'(a); bus.req1_wdata = d;
        end
    endtask

    task automatic step();
        int g;
        bit v0, v1, we0, we1, gw;
        logic [3:0] a0, a1, ga;
        logic [15:0] d0, d1, gd;
        logic [26:0] got, exp;
        @(negedge clk);
        v0 = bus.req0_valid; we0 = bus.req0_we;
        a0 = bus.req0_addr;  d0 = bus.req0_wdata;
        v1 = bus.req1_valid; we1 = bus.req1_we;
        a1 = bus.req1_addr;  d1 = bus.req1_wdata;
        got = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid,
               bus.rsp1_valid, bus.init_done, bus.sram_we,
               bus.sram_enable, bus.sram_addr, bus.sram_data_in};
        o_rsp0 = bus.rsp0_valid; o_rsp1 = bus.rsp1_valid;
        o_init = bus.init_done; o_addr = bus.sram_addr;
        o_rdata = bus.rsp_rdata;
        acc0 = v0 && bus.req0_ready;
        acc1 = v1 && bus.req1_ready;
        g = -1; gw = 0; ga = 0; gd = 0;
        exp = '0;
        if (!rst) begin
            if (m_cnt < 16) begin
                exp[21] = 1'b1;
                exp[19:16] = 4'(m_cnt);
            end else begin
                exp[22] = 1'b1;
                if (v0 && v1) g = (m_last == 0) ? 1 : 0;
                else if (v0) g = 0;
                else if (v1) g = 1;
                if (g == 0) begin gw = we0; ga = a0; gd = d0; end
                if (g == 1) begin gw = we1; ga = a1; gd = d1; end
                if (g >= 0) begin
                    exp[26] = (g == 0);
                    exp[25] = (g == 1);
                    exp[21] = gw;
                    exp[20] = !gw;
                    exp[19:16] = ga;
                    exp[15:0] = gd;
                end
            end
            exp[24] = m_have && m_id == 0;
            exp[23] = m_have && m_id == 1;
        end
        check("outputs", 32'(got), 32'(exp));
        if (!rst && m_have) check("rsp_rdata", 32'(o_rdata), 32'(m_data));
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_last = 1; m_have = 0;
        end else if (m_cnt < 16) begin
            m_mem[m_cnt] = 16'h0;
            m_cnt++;
            m_have = 0;
        end else begin
            m_have = 0;
            if (g >= 0) begin
                m_last = g;
                if (gw) m_mem[ga] = gd;
                else begin
                    m_have = 1; m_id = g; m_data = m_mem[ga];
                end
            end
        end
        #1;
    endtask

    task automatic xfer(input int id, input bit we, input int a,
                        input logic [15:0] d);
        bit done = 0;
        set_req(id, 1, we, a, d);
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = (id == 0) ? acc0 : acc1;
        end
        check("xfer_accept", 32'(done), 32'd1);
        set_req(id, 0, 0, 0, 16'h0);
    endtask

    task automatic reinit();
        for (int i = 0; i < 16; i++) begin
            step();
            check("init_addr", 32'(o_addr), 32'(i));
            check("init_busy", 32'(o_init), 32'd0);
        end
    endtask

    initial begin
        m_cnt = 0; m_last = 1; m_have = 0; m_id = 0; m_data = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 16'hx;
        set_req(0, 0, 0, 0, 16'h0);
        set_req(1, 0, 0, 0, 16'h0);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        reinit();

        set_req(0, 1, 1, 2, 16'hFACE);
        set_req(1, 1, 1, 6, 16'hDEAD);
        step();
        check("init_done", 32'(o_init), 32'd1);
        check("arb_g0", 32'({acc0, acc1}), 32'b10);
        set_req(0, 1, 0, 2, 16'h0);
        step();
        check("arb_g1", 32'({acc0, acc1}), 32'b01);
        set_req(1, 1, 0, 6, 16'h0);
        step();
        check("arb_g2", 32'({acc0, acc1}), 32'b10);
        set_req(0, 0, 0, 0, 16'h0);
        step();
        check("arb_g3", 32'({acc0, acc1}), 32'b01);
        check("rsp_face", {o_rsp0, o_rsp1, o_rdata}, {2'b10, 16'hFACE});
        set_req(1, 0, 0, 0, 16'h0);
        step();
        check("rsp_dead", {o_rsp0, o_rsp1, o_rdata}, {2'b01, 16'hDEAD});

        xfer(0, 1, 4, 16'hA5A5);
        xfer(0, 0, 4, 16'h0);
        step();
        check("rsp_a5a5", {o_rsp0, o_rsp1, o_rdata}, {2'b10, 16'hA5A5});

        xfer(1, 0, 9, 16'h0);
        step();
        check("rsp_zero9", {o_rsp0, o_rsp1, o_rdata}, {2'b01, 16'h0000});

        xfer(0, 1, 10, 16'hC0FF);
        xfer(1, 1, 15, 16'hEE00);
        set_req(0, 1, 0, 10, 16'h0);
        step();
        check("b2b_acc0", 32'(acc0), 32'd1);
        set_req(0, 0, 0, 0, 16'h0);
        set_req(1, 1, 0, 15, 16'h0);
        step();
        check("b2b_acc1", 32'(acc1), 32'd1);
        check("b2b_rsp0", {o_rsp0, o_rsp1, o_rdata}, {2'b10, 16'hC0FF});
        set_req(1, 0, 0, 0, 16'h0);
        step();
        check("b2b_rsp1", {o_rsp0, o_rsp1, o_rdata}, {2'b01, 16'hEE00});

        xfer(0, 0, 4, 16'h0);
        rst = 1'b1;
        step();
        check("rst_drop", 32'({o_rsp0, o_rsp1}), 32'd0);
        rst = 1'b0;
        reinit();
        xfer(0, 0, 4, 16'h0);
        step();
        check("rst_zero4", {o_rsp0, o_rsp1, o_rdata}, {2'b10, 16'h0000});

        for (int c = 0; c < 600; c++) begin
            if (!bus.req0_valid || acc0)
                set_req(0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 15), 16'($urandom));
            if (!bus.req1_valid || acc1)
                set_req(1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 15), 16'($urandom));
            rst = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
